tx_unit: RTL and testbench

Serial transmitter for the MiniUart; the sending counterpart of the receive unit.
- Accepts a byte from the CPU bus into a one-byte holding register.
- Shifts the byte out on TxD as an 8N1 frame, LSB first: start bit, 8 data bits, 1 stop bit.
- Shares the receiver's 8x-baud enable tick, so one bit time lasts OVERSAMPLE en_tx ticks.
- The holding register allows back-to-back frames with no idle gap.

---
 rtl/tx_unit.sv | 108 ++++++++++
 tb/tb_tx_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tx_unit.sv
// tx_unit: 8N1 UART transmitter with a one-byte holding register.
// A byte is shifted out LSB first, one bit every OVERSAMPLE en_tx ticks.
module tx_unit #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_tx,
    input  logic [7:0] d_in,
    input  logic       load,
    output logic       txd,
    output logic       ts,
    output logic       busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] SAMPLE_RELOAD = CW'(OVERSAMPLE - 1);
    localparam logic [2:0] BITS_RELOAD = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, BIT_SEND, STOP} state_t;

    state_t          state_q;
    logic [7:0]      hold_q;
    logic [7:0]      shift_q;
    logic            hold_valid_q;
    logic            txd_q;
    logic [CW-1:0]   cnt_sample_q;
    logic [2:0]      cnt_bits_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            shift_q      <= '0;
            hold_valid_q <= 1'b0;
            txd_q        <= 1'b1;
            cnt_sample_q <= '0;
            cnt_bits_q   <= '0;
        end else begin
            // Load and hold->shift transfer are mutually exclusive on hold_valid_q.
            if (load && !hold_valid_q) begin
                hold_q       <= d_in;
                hold_valid_q <= 1'b1;
            end
            if (en_tx) begin
                case (state_q)
                    IDLE: begin
                        if (hold_valid_q) begin
                            shift_q      <= hold_q;
                            hold_valid_q <= 1'b0;
                            txd_q        <= 1'b0;
                            cnt_sample_q <= SAMPLE_RELOAD;
                            state_q      <= START;
                        end else begin
                            txd_q <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_sample_q != '0) begin
                            cnt_sample_q <= cnt_sample_q - 1'b1;
                        end else begin
                            txd_q        <= shift_q[0];
                            shift_q      <= shift_q >> 1;
                            cnt_bits_q   <= BITS_RELOAD;
                            cnt_sample_q <= SAMPLE_RELOAD;
                            state_q      <= BIT_SEND;
                        end
                    end
                    BIT_SEND: begin
                        if (cnt_sample_q != '0) begin
                            cnt_sample_q <= cnt_sample_q - 1'b1;
                        end else if (cnt_bits_q != '0) begin
                            txd_q        <= shift_q[0];
                            shift_q      <= shift_q >> 1;
                            cnt_bits_q   <= cnt_bits_q - 1'b1;
                            cnt_sample_q <= SAMPLE_RELOAD;
                        end else begin
                            txd_q        <= 1'b1;
                            cnt_sample_q <= SAMPLE_RELOAD;
                            state_q      <= STOP;
                        end
                    end
                    STOP: begin
                        if (cnt_sample_q != '0) begin
                            cnt_sample_q <= cnt_sample_q - 1'b1;
                        end else if (hold_valid_q) begin
                            shift_q      <= hold_q;
                            hold_valid_q <= 1'b0;
                            txd_q        <= 1'b0;
                            cnt_sample_q <= SAMPLE_RELOAD;
                            state_q      <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        txd_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign txd  = txd_q;
    assign ts   = ~hold_valid_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_tx_unit.sv
// tb_tx_unit: directed scenarios for tx_unit, comparing sampled txd/busy/ts
// waveforms against frames built from the byte values.
module tb_tx_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_tx = 1'b1;
    logic [7:0] d_in = 8'h00;
    logic       load = 1'b0;
    logic       txd, ts, busy;

    int passed = 0;
    int total = 0;
    int en_period = 1;
    int en_ph = 0;
    logic [399:0] wt, wb, ws;

    tx_unit dut (.clk(clk), .rst(rst), .en_tx(en_tx), .d_in(d_in), .load(load),
                 .txd(txd), .ts(ts), .busy(busy));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        en_ph = (en_ph + 1 >= en_period) ? 0 : en_ph + 1;
        en_tx = (en_ph == 0);
    end

    function automatic logic [399:0] put_frame(logic [399:0] v, int start, logic [7:0] d, int bl);
        logic b;
        for (int j = 0; j < 10; j++) begin
            b = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
            for (int k = 0; k < bl; k++) v[start + j*bl + k] = b;
        end
        return v;
    endfunction

    function automatic logic [399:0] mark(logic [399:0] v, int a, int len, logic val);
        for (int k = 0; k < len; k++) v[a + k] = val;
        return v;
    endfunction

    task automatic load_byte(input logic [7:0] d);
        @(posedge clk); #1;
        d_in = d;
        load = 1'b1;
    endtask

    task automatic capture(input int n, input int k1, input logic [7:0] d1,
                           input int k2, input logic [7:0] d2);
        wt = '1; wb = '0; ws = '1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wt[i] = txd; wb[i] = busy; ws[i] = ts;
            load = 1'b0;
            if (i == k1) begin load = 1'b1; d_in = d1; end
            if (i == k2) begin load = 1'b1; d_in = d2; end
        end
        load = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        total++; if (txd !== 1'b1) $display("FAIL reset_txd got=%b exp=1", txd); else passed++;
        total++; if (ts !== 1'b1) $display("FAIL reset_ts got=%b exp=1", ts); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single;
        logic [399:0] et, eb;
        load_byte(8'h55);
        capture(90, -1, 8'h00, -1, 8'h00);
        et = put_frame('1, 1, 8'h55, 8);
        eb = mark('0, 1, 80, 1'b1);
        total++; if (wt[89:0] !== et[89:0]) $display("FAIL single_txd got=%h exp=%h", wt[89:0], et[89:0]); else passed++;
        total++; if (wb[89:0] !== eb[89:0]) $display("FAIL single_busy got=%h exp=%h", wb[89:0], eb[89:0]); else passed++;
        total++; if (ws[1:0] !== 2'b10) $display("FAIL single_ts_pulse got=%b exp=10", ws[1:0]); else passed++;
        total++; if (ws[89:2] !== {88{1'b1}}) $display("FAIL single_ts_after got=%h", ws[89:2]); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [399:0] et, eb, es;
        load_byte(8'hA5);
        capture(175, 1, 8'h3C, -1, 8'h00);
        et = put_frame(put_frame('1, 1, 8'hA5, 8), 81, 8'h3C, 8);
        eb = mark('0, 1, 160, 1'b1);
        es = mark(mark('1, 0, 1, 1'b0), 2, 79, 1'b0);
        total++; if (wt[174:0] !== et[174:0]) $display("FAIL b2b_txd got=%h exp=%h", wt[174:0], et[174:0]); else passed++;
        total++; if (wb[174:0] !== eb[174:0]) $display("FAIL b2b_busy got=%h exp=%h", wb[174:0], eb[174:0]); else passed++;
        total++; if (ws[174:0] !== es[174:0]) $display("FAIL b2b_ts got=%h exp=%h", ws[174:0], es[174:0]); else passed++;
    endtask

    task automatic test_ignored_load;
        logic [399:0] et, eb;
        load_byte(8'hA5);
        capture(260, 1, 8'h11, 30, 8'h22);
        et = put_frame(put_frame('1, 1, 8'hA5, 8), 81, 8'h11, 8);
        eb = mark('0, 1, 160, 1'b1);
        total++; if (ws[30] !== 1'b0) $display("FAIL ignored_ts_full got=%b exp=0", ws[30]); else passed++;
        total++; if (wt[259:0] !== et[259:0]) $display("FAIL ignored_txd got=%h exp=%h", wt[259:0], et[259:0]); else passed++;
        total++; if (wb[259:0] !== eb[259:0]) $display("FAIL ignored_busy got=%h exp=%h", wb[259:0], eb[259:0]); else passed++;
    endtask

    task automatic test_stop_edge;
        logic [399:0] et, eb;
        load_byte(8'h81);
        capture(175, 80, 8'hFF, -1, 8'h00);
        et = put_frame(put_frame('1, 1, 8'h81, 8), 82, 8'hFF, 8);
        eb = mark(mark('0, 1, 80, 1'b1), 82, 80, 1'b1);
        total++; if (wb[81] !== 1'b0) $display("FAIL stopedge_idle busy=%b exp=0", wb[81]); else passed++;
        total++; if (wt[82] !== 1'b0) $display("FAIL stopedge_start txd=%b exp=0", wt[82]); else passed++;
        total++; if (wt[174:0] !== et[174:0]) $display("FAIL stopedge_txd got=%h exp=%h", wt[174:0], et[174:0]); else passed++;
        total++; if (wb[174:0] !== eb[174:0]) $display("FAIL stopedge_busy got=%h exp=%h", wb[174:0], eb[174:0]); else passed++;
    endtask

    task automatic test_slow_tick;
        logic [399:0] et, eb;
        int s;
        en_period = 4;
        repeat (6) @(posedge clk);
        load_byte(8'hF0);
        capture(340, -1, 8'h00, -1, 8'h00);
        s = -1;
        for (int i = 339; i >= 0; i--) if (wt[i] === 1'b0) s = i;
        total++;
        if (s < 1 || s > 4) begin
            $display("FAIL slow_latency start_idx=%0d exp=1..4", s);
            s = 1;
        end else passed++;
        et = put_frame('1, s, 8'hF0, 32);
        eb = mark('0, s, 320, 1'b1);
        total++; if (wt[339:0] !== et[339:0]) $display("FAIL slow_txd got=%h exp=%h", wt[339:0], et[339:0]); else passed++;
        total++; if (wb[339:0] !== eb[339:0]) $display("FAIL slow_busy got=%h exp=%h", wb[339:0], eb[339:0]); else passed++;
        en_period = 1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        load_byte(8'h00);
        capture(30, -1, 8'h00, -1, 8'h00);
        total++; if (txd !== 1'b0 || busy !== 1'b1) $display("FAIL midrst_pre txd=%b busy=%b exp=0,1", txd, busy); else passed++;
        rst = 1'b0;
        #1;
        total++; if (txd !== 1'b1) $display("FAIL midrst_txd got=%b exp=1", txd); else passed++;
        total++; if (ts !== 1'b1) $display("FAIL midrst_ts got=%b exp=1", ts); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
        #1 rst = 1'b1;
        capture(100, -1, 8'h00, -1, 8'h00);
        total++; if (wt[99:0] !== {100{1'b1}}) $display("FAIL midrst_idle_txd got=%h", wt[99:0]); else passed++;
        total++; if (wb[99:0] !== {100{1'b0}}) $display("FAIL midrst_idle_busy got=%h", wb[99:0]); else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_ignored_load;
        test_stop_edge;
        test_slow_tick;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
